pc_call_stack: RTL and testbench

- Redirect source for the program counter. Generates the load strobe and load value that the PC consumes.
- Holds a hardware return-address stack:
  - CALL pushes the return address PC_CUR+1 and redirects to the call target.
  - RET pops the stack and redirects to the popped address.
  - A taken branch redirects without touching the stack.
- Sits between the decoder/branch logic and the PC. Its outputs drive the PC's load-enable and load-data inputs.

---
 rtl/otter_pkg.sv | 18 +
 rtl/pc_call_stack_if.sv | 33 +++
 rtl/pc_call_stack_ras_mem.sv | 26 ++
 rtl/pc_call_stack.sv | 134 +++++++++++++
 tb/tb_pc_call_stack.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/otter_pkg.sv
// Shared PC-redirect types and constants.
// Used by the return-address stack and its neighbours.
package otter_pkg;

    localparam int ADDR_W = 10;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = '0;

    typedef logic [ADDR_W-1:0] pc_addr_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CALL,
        RD_RET,
        RD_BR
    } redirect_src_t;

endpackage

// File: rtl/pc_call_stack_if.sv
// Request/redirect bundle between decode/branch logic and the PC.
// The master drives requests; the slave (stack) drives the redirect.
interface pc_call_stack_if #(
    parameter int ADDR_W = otter_pkg::ADDR_W,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] PC_CUR;
    logic              CALL;
    logic [ADDR_W-1:0] CALL_TGT;
    logic              RET;
    logic              BR_TAKEN;
    logic [ADDR_W-1:0] BR_TGT;
    logic              PC_LD;
    logic [ADDR_W-1:0] PC_DATA;
    logic [CW-1:0]     COUNT;
    logic              FULL;
    logic              EMPTY;
    logic              OVF;
    logic              UNF;

    modport master (
        output PC_CUR, CALL, CALL_TGT, RET, BR_TAKEN, BR_TGT,
        input  PC_LD, PC_DATA, COUNT, FULL, EMPTY, OVF, UNF
    );

    modport slave (
        input  PC_CUR, CALL, CALL_TGT, RET, BR_TAKEN, BR_TGT,
        output PC_LD, PC_DATA, COUNT, FULL, EMPTY, OVF, UNF
    );

endinterface

// File: rtl/pc_call_stack_ras_mem.sv
// Return-address storage: one synchronous write port and an
// asynchronous read port; contents are intentionally not reset.
module pc_call_stack_ras_mem #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PW-1:0]     waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PW-1:0]     raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_call_stack.sv
// PC redirect source with a circular hardware return-address stack.
// Priority is CALL > RET > BR_TAKEN; outputs are same-cycle.
module pc_call_stack #(
    parameter int ADDR_W = otter_pkg::ADDR_W,
    parameter int DEPTH  = 8
) (
    input logic          clk,
    input logic          RST,
    pc_call_stack_if.slave bus
);
    import otter_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    redirect_src_t     src;
    logic              call_req;
    logic              ret_req;
    logic              br_req;

    logic [PW-1:0]     top_q, top_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [PW-1:0]     top_inc;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_we;
    logic              full;
    logic              empty;
    logic              pc_ld;
    logic [ADDR_W-1:0] pc_data;

    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);
    assign top_inc  = top_q + 1'b1;
    assign ret_addr = bus.PC_CUR + 1'b1;

    // Masked so the one-hot select stays truly unique.
    assign call_req = bus.CALL;
    assign ret_req  = bus.RET & ~bus.CALL;
    assign br_req   = bus.BR_TAKEN & ~bus.CALL & ~bus.RET;

    always_comb begin
        src = RD_NONE;
        if (!RST) begin
            unique case (1'b1)
                call_req: src = RD_CALL;
                ret_req:  src = RD_RET;
                br_req:   src = RD_BR;
                default:  src = RD_NONE;
            endcase
        end
    end

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        mem_we  = 1'b0;
        pc_ld   = 1'b0;
        pc_data = '0;

        unique case (src)
            RD_CALL: begin
                pc_ld   = 1'b1;
                pc_data = bus.CALL_TGT;
                mem_we  = 1'b1;
                top_d   = top_inc;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            RD_RET: begin
                pc_ld = 1'b1;
                if (empty) begin
                    pc_data = ADDR_W'(RESET_VECTOR);
                    unf_d   = 1'b1;
                end else begin
                    pc_data = mem_rdata;
                    top_d   = top_q - 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            RD_BR: begin
                pc_ld   = 1'b1;
                pc_data = bus.BR_TGT;
            end
            default: begin
                pc_ld = 1'b0;
            end
        endcase

        if (RST) begin
            top_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        top_q   <= top_d;
        count_q <= count_d;
        ovf_q   <= ovf_d;
        unf_q   <= unf_d;
    end

    pc_call_stack_ras_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (top_inc),
        .wdata (ret_addr),
        .raddr (top_q),
        .rdata (mem_rdata)
    );

    assign bus.PC_LD   = pc_ld;
    assign bus.PC_DATA = pc_data;
    assign bus.COUNT   = count_q;
    assign bus.FULL    = full;
    assign bus.EMPTY   = empty;
    assign bus.OVF     = ovf_q;
    assign bus.UNF     = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack with hand-computed expectations.
module tb_pc_call_stack;

    localparam int AW = 10;
    localparam int DP = 8;

    logic clk;
    logic RST;
    int   total;
    int   bad;

    pc_call_stack_if #(.ADDR_W(AW), .DEPTH(DP)) bus ();

    pc_call_stack #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.CALL     = 1'b0;
        bus.RET      = 1'b0;
        bus.BR_TAKEN = 1'b0;
        bus.CALL_TGT = '0;
        bus.BR_TGT   = '0;
        bus.PC_CUR   = '0;
    endtask

    task automatic req(input logic c, input logic r, input logic b,
                       input int pc, input int ct, input int bt);
        bus.CALL     = c;
        bus.RET      = r;
        bus.BR_TAKEN = b;
        bus.PC_CUR   = AW'(pc);
        bus.CALL_TGT = AW'(ct);
        bus.BR_TGT   = AW'(bt);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0;
        #1;

        chk("rst_ld", 32'(bus.PC_LD), 0);
        chk("rst_cnt", 32'(bus.COUNT), 0);
        chk("rst_empty", 32'(bus.EMPTY), 1);
        chk("rst_full", 32'(bus.FULL), 0);
        chk("rst_ovf", 32'(bus.OVF), 0);
        chk("rst_unf", 32'(bus.UNF), 0);

        req(1, 0, 0, 'h010, 'h200, 0);
        chk("call_ld", 32'(bus.PC_LD), 1);
        chk("call_data", 32'(bus.PC_DATA), 'h200);
        tick();
        chk("call_cnt", 32'(bus.COUNT), 1);
        chk("idle_ld", 32'(bus.PC_LD), 0);
        chk("idle_data", 32'(bus.PC_DATA), 0);
        req(0, 1, 0, 'h200, 0, 0);
        chk("ret_ld", 32'(bus.PC_LD), 1);
        chk("ret_data", 32'(bus.PC_DATA), 'h011);
        tick();
        chk("ret_cnt", 32'(bus.COUNT), 0);
        chk("ret_empty", 32'(bus.EMPTY), 1);

        for (int i = 0; i < 9; i++) begin
            req(1, 0, 0, i, 'h100 + i, 0);
            chk("nest_data", 32'(bus.PC_DATA), 32'('h100 + i));
            tick();
            if (i == 7) begin
                chk("full8", 32'(bus.FULL), 1);
                chk("ovf8", 32'(bus.OVF), 0);
            end
        end
        chk("ovf9", 32'(bus.OVF), 1);
        chk("cnt9", 32'(bus.COUNT), 8);
        chk("full9", 32'(bus.FULL), 1);

        for (int k = 0; k < 8; k++) begin
            req(0, 1, 0, 'h300, 0, 0);
            chk("pop_data", 32'(bus.PC_DATA), 32'(9 - k));
            tick();
        end
        chk("pop_cnt", 32'(bus.COUNT), 0);
        chk("pop_empty", 32'(bus.EMPTY), 1);
        chk("pop_ovf", 32'(bus.OVF), 1);

        req(0, 1, 0, 'h050, 0, 0);
        chk("unf_ld", 32'(bus.PC_LD), 1);
        chk("unf_data", 32'(bus.PC_DATA), 0);
        tick();
        chk("unf_flag", 32'(bus.UNF), 1);
        chk("unf_cnt", 32'(bus.COUNT), 0);
        chk("unf_ovf", 32'(bus.OVF), 1);

        req(1, 1, 1, 'h3FF, 'h040, 'h123);
        chk("prio_data", 32'(bus.PC_DATA), 'h040);
        tick();
        chk("prio_cnt", 32'(bus.COUNT), 1);

        req(0, 0, 1, 'h041, 0, 'h123);
        chk("br_ld", 32'(bus.PC_LD), 1);
        chk("br_data", 32'(bus.PC_DATA), 'h123);
        tick();
        chk("br_cnt", 32'(bus.COUNT), 1);

        req(0, 1, 0, 'h124, 0, 0);
        chk("wrap_data", 32'(bus.PC_DATA), 0);
        tick();
        chk("wrap_cnt", 32'(bus.COUNT), 0);

        req(1, 0, 0, 'h020, 'h080, 0);
        tick();
        req(0, 1, 0, 'h080, 0, 0);
        chk("b2b_data", 32'(bus.PC_DATA), 'h021);
        tick();
        for (int i = 0; i < 3; i++) begin
            req(1, 0, 0, 'h030 + i, 'h090, 0);
            tick();
        end
        chk("pre_rst_cnt", 32'(bus.COUNT), 3);

        RST = 1'b1;
        req(1, 0, 0, 'h033, 'h0A0, 0);
        chk("rst_call_ld", 32'(bus.PC_LD), 0);
        @(posedge clk);
        #1;
        RST = 1'b0;
        idle();
        #1;
        chk("rst_mid_cnt", 32'(bus.COUNT), 0);
        chk("rst_mid_ovf", 32'(bus.OVF), 0);
        chk("rst_mid_unf", 32'(bus.UNF), 0);
        req(0, 1, 0, 'h000, 0, 0);
        chk("rst_ret_data", 32'(bus.PC_DATA), 0);
        chk("rst_ret_ld", 32'(bus.PC_LD), 1);
        tick();
        chk("rst_ret_unf", 32'(bus.UNF), 1);
        chk("rst_ret_cnt", 32'(bus.COUNT), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
